// File: rtl/deepfifo_axi_responder.sv
`default_nettype none
// ============================================================================
// Module   : deepfifo_axi_responder
// Brief    : AXI4 512-bit INCR-burst responder backed by an on-chip word array,
//            with optional ready backpressure, beat counters and error flag.
// Revision : 1.0  initial release
// ============================================================================
module deepfifo_axi_responder #(
   parameter int LOG2_DEPTH    = 10,
   parameter int WREADY_GAP    = 0,
   parameter int ARREADY_DELAY = 0
) (
   input  logic         axi_clk,
   input  logic         sys_rst,
   // write address
   input  logic [31:0]  axi_awaddr,
   input  logic [7:0]   axi_awlen,
   input  logic [2:0]   axi_awsize,
   input  logic [1:0]   axi_awburst,
   input  logic         axi_awvalid,
   output logic         axi_awready,
   // write data
   input  logic [511:0] axi_wdata,
   input  logic [63:0]  axi_wstrb,
   input  logic         axi_wlast,
   input  logic         axi_wvalid,
   output logic         axi_wready,
   // write response
   output logic         axi_bvalid,
   input  logic         axi_bready,
   // read address
   input  logic [31:0]  axi_araddr,
   input  logic [7:0]   axi_arlen,
   input  logic [2:0]   axi_arsize,
   input  logic [1:0]   axi_arburst,
   input  logic         axi_arvalid,
   output logic         axi_arready,
   // read data
   output logic [511:0] axi_rdata,
   output logic         axi_rlast,
   output logic         axi_rvalid,
   input  logic         axi_rready,
   // status
   output logic [31:0]  wr_beat_count,
   output logic [31:0]  rd_beat_count,
   output logic         protocol_err
);

   localparam int          c_DEPTH      = 1 << LOG2_DEPTH;
   localparam logic [1:0]  c_W_IDLE     = 2'd0;
   localparam logic [1:0]  c_W_DATA     = 2'd1;
   localparam logic [1:0]  c_W_RESP     = 2'd2;
   localparam logic [0:0]  c_R_IDLE     = 1'b0;
   localparam logic [0:0]  c_R_DATA     = 1'b1;
   localparam logic [2:0]  c_SIZE_64B   = 3'd6;
   localparam logic [1:0]  c_BURST_INCR = 2'b01;
   localparam logic [15:0] c_AR_DLY     = 16'(ARREADY_DELAY);
   localparam logic        c_AR_IMM     = (ARREADY_DELAY == 0);

   logic [511:0] r_mem [0:c_DEPTH-1];

   // ------------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------------
   logic [1:0]            r_wstate;
   logic                  r_awready;
   logic [LOG2_DEPTH-1:0] r_widx;
   logic [7:0]            r_awlen;
   logic [7:0]            r_wbeat;
   logic [31:0]           r_wr_cnt;
   logic                  r_perr;

   logic w_aw_fire;
   logic w_wready;
   logic w_wstall;
   logic w_w_fire;
   logic w_w_last_beat;
   logic w_aw_bad;
   logic w_ar_bad;
   logic w_wlast_bad;

   assign w_aw_fire     = axi_awvalid & r_awready;
   assign w_wready      = (r_wstate == c_W_DATA) & ~w_wstall;
   assign w_w_fire      = axi_wvalid & w_wready;
   assign w_w_last_beat = (r_wbeat == r_awlen);
   assign w_aw_bad      = w_aw_fire & ((axi_awsize != c_SIZE_64B) | (axi_awburst != c_BURST_INCR));
   assign w_wlast_bad   = w_w_fire & (axi_wlast != w_w_last_beat);

   generate
      if (WREADY_GAP != 0) begin : g_wgap
         localparam int c_GW = $clog2(WREADY_GAP + 1);
         logic [c_GW-1:0] r_gap_cnt;
         logic            r_stall;

         // The gap counter restarts with every burst so the stall pattern is
         // the same for each burst regardless of history.
         always_ff @(posedge axi_clk) begin
            if (sys_rst) begin
               r_gap_cnt <= '0;
               r_stall   <= 1'b0;
            end else begin
               r_stall <= 1'b0;
               if (w_aw_fire) begin
                  r_gap_cnt <= '0;
               end else if (w_w_fire) begin
                  if (r_gap_cnt == c_GW'(WREADY_GAP - 1)) begin
                     r_gap_cnt <= '0;
                     r_stall   <= 1'b1;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                  end
               end
            end
         end
         assign w_wstall = r_stall;
      end else begin : g_no_wgap
         assign w_wstall = 1'b0;
      end
   endgenerate

   always_ff @(posedge axi_clk) begin
      if (sys_rst) begin
         r_wstate  <= c_W_IDLE;
         r_awready <= 1'b0;
         r_widx    <= '0;
         r_awlen   <= '0;
         r_wbeat   <= '0;
         r_wr_cnt  <= '0;
      end else begin
         case (r_wstate)
            c_W_IDLE: begin
               r_awready <= 1'b1;
               if (w_aw_fire) begin
                  r_wstate  <= c_W_DATA;
                  r_awready <= 1'b0;
                  r_widx    <= axi_awaddr[LOG2_DEPTH+5:6];
                  r_awlen   <= axi_awlen;
                  r_wbeat   <= '0;
               end
            end
            c_W_DATA: begin
               if (w_w_fire) begin
                  r_widx   <= r_widx + 1'b1;
                  r_wbeat  <= r_wbeat + 8'd1;
                  r_wr_cnt <= r_wr_cnt + 32'd1;
                  // Termination follows the beat count, never wlast.
                  if (w_w_last_beat) begin
                     r_wstate <= c_W_RESP;
                  end
               end
            end
            c_W_RESP: begin
               if (axi_bready) begin
                  r_wstate <= c_W_IDLE;
               end
            end
            default: begin
               r_wstate  <= c_W_IDLE;
               r_awready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge axi_clk) begin
      if (w_w_fire && !sys_rst) begin
         for (int b = 0; b < 64; b++) begin
            if (axi_wstrb[b]) begin
               r_mem[r_widx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read channel: one fetch register in front of the output register lets
   // beats stream back-to-back while rready stays high.
   // ------------------------------------------------------------------------
   logic [0:0]            r_rstate;
   logic                  r_arready;
   logic [15:0]           r_ar_dly;
   logic [LOG2_DEPTH-1:0] r_ridx;
   logic [7:0]            r_arlen;
   logic [8:0]            r_issued;
   logic [511:0]          r_fetch;
   logic                  r_f_vld;
   logic                  r_f_last;
   logic [511:0]          r_rdata;
   logic                  r_rvalid;
   logic                  r_rlast;
   logic [31:0]           r_rd_cnt;

   logic                  w_ar_fire;
   logic                  w_r_fire;
   logic                  w_out_load;
   logic                  w_more;
   logic                  w_issue;
   logic [LOG2_DEPTH-1:0] w_fetch_idx;
   logic                  w_fetch_last;

   assign w_ar_fire  = axi_arvalid & r_arready;
   assign w_r_fire   = r_rvalid & axi_rready;
   assign w_out_load = r_f_vld & (~r_rvalid | axi_rready);
   assign w_more     = (r_issued <= {1'b0, r_arlen});
   assign w_issue    = (r_rstate == c_R_IDLE) ? w_ar_fire
                                              : (w_more & (~r_f_vld | w_out_load));
   assign w_ar_bad   = w_ar_fire & ((axi_arsize != c_SIZE_64B) | (axi_arburst != c_BURST_INCR));

   // The first word is fetched on the AR handshake edge straight from araddr.
   always_comb begin
      w_fetch_idx  = r_ridx;
      w_fetch_last = ({1'b0, r_arlen} == r_issued);
      if (r_rstate == c_R_IDLE) begin
         w_fetch_idx  = axi_araddr[LOG2_DEPTH+5:6];
         w_fetch_last = (axi_arlen == 8'd0);
      end
   end

   always_ff @(posedge axi_clk) begin
      if (w_issue && !sys_rst) begin
         r_fetch <= r_mem[w_fetch_idx];
      end
   end

   always_ff @(posedge axi_clk) begin
      if (sys_rst) begin
         r_rstate  <= c_R_IDLE;
         r_arready <= 1'b0;
         r_ar_dly  <= '0;
         r_ridx    <= '0;
         r_arlen   <= '0;
         r_issued  <= '0;
         r_f_vld   <= 1'b0;
         r_f_last  <= 1'b0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rd_cnt  <= '0;
      end else begin
         if (w_issue) begin
            r_f_vld  <= 1'b1;
            r_f_last <= w_fetch_last;
         end else if (w_out_load) begin
            r_f_vld  <= 1'b0;
         end

         if (w_out_load) begin
            r_rvalid <= 1'b1;
            r_rlast  <= r_f_last;
            r_rdata  <= r_fetch;
         end else if (w_r_fire) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end

         if (w_r_fire) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end

         case (r_rstate)
            c_R_IDLE: begin
               if (w_ar_fire) begin
                  r_rstate  <= c_R_DATA;
                  r_arready <= 1'b0;
                  r_ridx    <= w_fetch_idx + 1'b1;
                  r_arlen   <= axi_arlen;
                  r_issued  <= 9'd1;
               end else if (!r_arready) begin
                  if ((r_ar_dly + 16'd1) >= c_AR_DLY) begin
                     r_arready <= 1'b1;
                  end else begin
                     r_ar_dly <= r_ar_dly + 16'd1;
                  end
               end
            end
            c_R_DATA: begin
               if (w_issue) begin
                  r_ridx   <= r_ridx + 1'b1;
                  r_issued <= r_issued + 9'd1;
               end
               if (w_r_fire && r_rlast) begin
                  r_rstate  <= c_R_IDLE;
                  r_arready <= c_AR_IMM;
                  r_ar_dly  <= '0;
               end
            end
            default: begin
               r_rstate  <= c_R_IDLE;
               r_arready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge axi_clk) begin
      if (sys_rst) begin
         r_perr <= 1'b0;
      end else if (w_aw_bad || w_ar_bad || w_wlast_bad) begin
         r_perr <= 1'b1;
      end
   end

   logic w_unused;
   assign w_unused = &{1'b0, axi_awaddr[31:LOG2_DEPTH+6], axi_awaddr[5:0],
                       axi_araddr[31:LOG2_DEPTH+6], axi_araddr[5:0]};

   assign axi_awready   = r_awready;
   assign axi_wready    = w_wready;
   assign axi_bvalid    = (r_wstate == c_W_RESP);
   assign axi_arready   = r_arready;
   assign axi_rdata     = r_rdata;
   assign axi_rlast     = r_rlast;
   assign axi_rvalid    = r_rvalid;
   assign wr_beat_count = r_wr_cnt;
   assign rd_beat_count = r_rd_cnt;
   assign protocol_err  = r_perr;

endmodule
`default_nettype wire

// File: doc/deepfifo_axi_responder.md
Name: deepfifo_axi_responder

Overview:
- AXI4 slave (responder) with a 512-bit data path, backed by an on-chip word array.
- Serves as the memory-side end of the deepfifo AXI master. It stands in for the DDR controller in simulation and board bring-up.
- Accepts INCR write and read bursts, stores and returns data with per-byte strobes, and can inject ready backpressure.
- Exposes beat counters and a sticky protocol-error flag.

Parameters:
- LOG2_DEPTH, 10, log2 of array depth in 64-byte words (default 1024 words = 64 KiB).
- WREADY_GAP, 0, if nonzero, wready drops for 1 cycle after every WREADY_GAP accepted W beats.
- ARREADY_DELAY, 0, cycles arready stays low after entering R_IDLE before asserting.

Ports:
- axi_clk in 1: the only clock.
- sys_rst in 1: synchronous, active-high reset.
- axi_awaddr in 32: write burst byte address.
- axi_awlen in 8: write beats minus 1.
- axi_awsize in 3: must be 6.
- axi_awburst in 2: must be 2'b01 (INCR).
- axi_awvalid in 1 / axi_awready out 1: AW handshake.
- axi_wdata in 512 / axi_wstrb in 64: write data and byte enables.
- axi_wlast in 1: final write beat.
- axi_wvalid in 1 / axi_wready out 1: W handshake.
- axi_bvalid out 1 / axi_bready in 1: write response handshake (OKAY implied; no bresp).
- axi_araddr in 32: read burst byte address.
- axi_arlen in 8: read beats minus 1.
- axi_arsize in 3 / axi_arburst in 2: same rules as AW.
- axi_arvalid in 1 / axi_arready out 1: AR handshake.
- axi_rdata out 512: read data.
- axi_rlast out 1: final read beat.
- axi_rvalid out 1 / axi_rready in 1: R handshake.
- wr_beat_count out 32: total accepted W beats.
- rd_beat_count out 32: total completed R beats.
- protocol_err out 1: sticky error flag.

Behaviour:
- Reset values (sys_rst sampled high on an axi_clk edge): all ready/valid outputs 0, rlast 0, rdata 0, counters 0, protocol_err 0, both FSMs idle. Array contents are not cleared.
- Reset mid-burst: both FSMs abort to idle on the next edge with no B or R completion. Words already written stay in the array.
- Address mapping: word index = addr[LOG2_DEPTH+5:6]. Low 6 bits are ignored. Upper bits are ignored, so addresses alias modulo the array size.
- Each beat increments the word index by 1, modulo 2^LOG2_DEPTH. A burst crossing the array top wraps to word 0 silently.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch the index and awlen, then go to W_DATA. awready=0 outside W_IDLE.
  - W_DATA: wready=1 except during WREADY_GAP stall cycles. On each wvalid&wready, write bytes b where wstrb[b]=1, increment the index, and increment wr_beat_count.
  - W_DATA exits to W_RESP on the beat where the beat counter equals awlen. If wlast disagrees with the counter on any beat, set protocol_err; the count still governs termination.
  - W_RESP: bvalid=1, held until bready, then return to W_IDLE.
  - No W data is accepted before the AW handshake (wready=0 in W_IDLE).
- Read FSM states are R_IDLE and R_DATA.
  - R_IDLE: arready=1 after ARREADY_DELAY cycles. On handshake, latch the index and arlen, then go to R_DATA.
  - R_DATA: the first rvalid comes exactly 2 cycles after the AR handshake cycle. rdata, rvalid and rlast are registered.
  - While rvalid=1 and rready=0, rdata, rlast and rvalid must hold stable.
  - Beats stream one per cycle while rready stays high, with no bubbles. This requires a one-word prefetch/skid register.
  - rlast=1 only on beat arlen. After that handshake, rvalid drops and the FSM returns to R_IDLE. rd_beat_count increments per R handshake.
- Write and read channels run independently and concurrently.
- Same-word collision (write and read of one word in the same cycle): the read returns the old data. Any read issued after B completes returns the new data.
- awsize/arsize != 6 or burst != INCR: set protocol_err and still process as 64-byte INCR beats.
- Counters wrap at 2^32. protocol_err clears only on reset.

Test Plan:
- Reset: hold sys_rst 3 cycles while awvalid=arvalid=1 -> all outputs 0. After release, awready=arready=1 the next cycle (delays=0).
- Single write then read: AW addr 0x40, len 0, wdata=pattern A, wstrb all-ones; B handshake; AR addr 0x40, len 0 -> rdata=A, rlast=1, rvalid 2 cycles after AR; wr_beat_count=rd_beat_count=1.
- 16-beat burst with partial strobe: write beats k=0..15 at 0x1000, data=k replicated. Beat 5 uses wstrb=64'h00000000_0000FFFF over prior contents 0. Read back 16 beats -> beat 5 has only the low 16 bytes = 5, the rest 0. rlast only on beat 15.
- Backpressure: WREADY_GAP=3, write 8 beats -> wready low 1 cycle after beats 3 and 6; data intact. On read, toggle rready 1-0 -> rdata stable while stalled; all 8 words correct.
- Wrap: LOG2_DEPTH=4, write 4 beats at word 14 -> data lands at words 14, 15, 0, 1. Read at word 0 returns beats 2 and 3.
- Errors: wlast asserted on beat 2 of a len=3 burst -> protocol_err=1, B still after beat 4. Separately, awsize=5 -> protocol_err=1. Reset clears the flag.
